// File: rtl/gf_muls_scl_arb.sv
// rtl/gf_muls_scl_arb.sv - two-requester round-robin front end for a shared GF(2^2) multiply-and-scale-by-N unit
//
// Purpose:
//   Two requesters share one multiply-and-scale-by-N datapath. A round-robin
//   arbiter grants at most one operand pair per cycle into a single stage
//   register. The next edge writes the result into that requester's result slot.
//   The slot holds the result until the requester consumes it.
//
// Ports:
//   clk                  sole clock, rising edge
//   rst_n                asynchronous active-low reset
//   req{0,1}_valid       requester presents an operand pair
//   req{0,1}_ready       operand pair accepted this cycle (combinational)
//   req{0,1}_a/_b [1:0]  GF(2^2) operands, basis [Omega^2,Omega]
//   rsp{0,1}_valid       result held for requester
//   rsp{0,1}_ready       requester consumes its result
//   rsp{0,1}_q    [1:0]  result, forced to zero while rsp valid is low
//   op_count      [7:0]  accepted operations, wraps 255 -> 0

module gf_muls_scl_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_a,
    input  logic [1:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_a,
    input  logic [1:0] req1_b,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [1:0] rsp0_q,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [1:0] rsp1_q,
    output logic [7:0] op_count
);

    // Product in GF(2^2) combined with the scale by N, normal basis [Omega^2,Omega].
    function automatic logic [1:0] gf_muls_scl(input logic [1:0] a, input logic [1:0] b);
        logic t;
        logic p;
        logic q;
        t = ~(a[0] & b[0]);
        p = ~((a[1] ^ a[0]) & (b[1] ^ b[0])) ^ t;
        q = ~(a[1] & b[1]) ^ t;
        return {p, q};
    endfunction

    logic       stage_valid;
    logic       stage_id;
    logic [1:0] stage_a;
    logic [1:0] stage_b;
    logic [1:0] stage_q;
    logic       prio;        // 0: requester 0 wins a tie, 1: requester 1 wins
    logic       elig0;
    logic       elig1;
    logic       grant0;
    logic       grant1;
    logic       consume0;
    logic       consume1;
    logic       drain0;
    logic       drain1;

    assign consume0 = rsp0_valid & rsp0_ready;
    assign consume1 = rsp1_valid & rsp1_ready;

    assign drain0 = stage_valid & ~stage_id;
    assign drain1 = stage_valid &  stage_id;

    // A requester with an op still in the stage is held off. This stops two
    // results for one slot from overlapping and gives 1 op per 2 cycles per
    // requester.
    assign elig0 = req0_valid & ~drain0 & (~rsp0_valid | consume0);
    assign elig1 = req1_valid & ~drain1 & (~rsp1_valid | consume1);

    // rst_n gating keeps both readies low while reset is asserted, even if a
    // requester is already presenting.
    assign grant0 = rst_n & elig0 & (~elig1 | ~prio);
    assign grant1 = rst_n & elig1 & (~elig0 |  prio);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign stage_q = gf_muls_scl(stage_a, stage_b);

    // The stage always drains on the following edge. The target slot is either
    // empty or being consumed, because eligibility required that at accept time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_id    <= 1'b0;
            stage_a     <= 2'b00;
            stage_b     <= 2'b00;
        end else begin
            stage_valid <= grant0 | grant1;
            if (grant0) begin
                stage_id <= 1'b0;
                stage_a  <= req0_a;
                stage_b  <= req0_b;
            end else if (grant1) begin
                stage_id <= 1'b1;
                stage_a  <= req1_a;
                stage_b  <= req1_b;
            end
        end
    end

    // The pointer moves only when an operand pair is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (grant0) begin
            prio <= 1'b1;
        end else if (grant1) begin
            prio <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= 8'd0;
        end else if (grant0 | grant1) begin
            op_count <= op_count + 8'd1;
        end
    end

    // A refill from the stage takes precedence over clearing on consume, so
    // valid stays high when both happen on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_q     <= 2'b00;
        end else if (drain0) begin
            rsp0_valid <= 1'b1;
            rsp0_q     <= stage_q;
        end else if (consume0) begin
            rsp0_valid <= 1'b0;
            rsp0_q     <= 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid <= 1'b0;
            rsp1_q     <= 2'b00;
        end else if (drain1) begin
            rsp1_valid <= 1'b1;
            rsp1_q     <= stage_q;
        end else if (consume1) begin
            rsp1_valid <= 1'b0;
            rsp1_q     <= 2'b00;
        end
    end

endmodule

// File: tb/tb_gf_muls_scl_arb.sv
// tb/tb_gf_muls_scl_arb.sv - directed self-checking bench for gf_muls_scl_arb

module tb_gf_muls_scl_arb;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic       req0_ready;
    logic [1:0] req0_a;
    logic [1:0] req0_b;
    logic       req1_valid;
    logic       req1_ready;
    logic [1:0] req1_a;
    logic [1:0] req1_b;
    logic       rsp0_valid;
    logic       rsp0_ready;
    logic [1:0] rsp0_q;
    logic       rsp1_valid;
    logic       rsp1_ready;
    logic [1:0] rsp1_q;
    logic [7:0] op_count;

    int checks;
    int failures;

    gf_muls_scl_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_q     (rsp0_q),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_q     (rsp1_q),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a     = 2'b00;
        req0_b     = 2'b00;
        req1_a     = 2'b00;
        req1_b     = 2'b00;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clear_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_q", rsp0_q, 0);
        chk("rst_op_count", op_count, 0);
        tick();
        tick();

        // Single op: accept in the first cycle out of reset, result two cycles later.
        rst_n = 1'b1;
        clear_inputs();
        req0_valid = 1'b1;
        req0_a = 2'b01;
        req0_b = 2'b01;
        rsp0_ready = 1'b1;
        #1;
        chk("first_ready0", req0_ready, 1);
        chk("first_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("single_count", op_count, 1);
        chk("single_n1_valid", rsp0_valid, 0);
        tick();
        chk("single_n2_valid", rsp0_valid, 1);
        chk("single_q", rsp0_q, 2'b01);
        tick();
        chk("single_consumed_valid", rsp0_valid, 0);
        chk("single_consumed_q", rsp0_q, 0);

        // Both requesting every cycle: grants alternate starting from requester 0.
        do_reset();
        req0_valid = 1'b1;
        req0_a = 2'b11;
        req0_b = 2'b11;
        req1_valid = 1'b1;
        req1_a = 2'b10;
        req1_b = 2'b10;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rr_ready0_%0d", k), req0_ready, (k % 2 == 0) ? 8'd1 : 8'd0);
            chk($sformatf("rr_ready1_%0d", k), req1_ready, (k % 2 == 1) ? 8'd1 : 8'd0);
            chk($sformatf("rr_rsp0_valid_%0d", k), rsp0_valid, (k >= 2 && k % 2 == 0) ? 8'd1 : 8'd0);
            chk($sformatf("rr_rsp0_q_%0d", k), rsp0_q, (k >= 2 && k % 2 == 0) ? 8'h2 : 8'h0);
            chk($sformatf("rr_rsp1_valid_%0d", k), rsp1_valid, (k >= 3 && k % 2 == 1) ? 8'd1 : 8'd0);
            chk($sformatf("rr_rsp1_q_%0d", k), rsp1_q, (k >= 3 && k % 2 == 1) ? 8'h3 : 8'h0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("rr_count", op_count, 8);

        // Back-pressure: result held, no new grant until the consume cycle.
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        req0_valid = 1'b1;
        req0_a = 2'b00;
        req0_b = 2'b10;
        #1;
        chk("bp_d0_ready", req0_ready, 1);
        tick();
        #1;
        chk("bp_d1_ready", req0_ready, 0);
        tick();
        chk("bp_d2_valid", rsp0_valid, 1);
        chk("bp_d2_q", rsp0_q, 2'b00);
        chk("bp_d2_ready", req0_ready, 0);
        tick();
        chk("bp_d3_valid", rsp0_valid, 1);
        chk("bp_d3_ready_held", req0_ready, 0);
        rsp0_ready = 1'b1;
        req0_a = 2'b11;
        req0_b = 2'b11;
        #1;
        chk("bp_d3_ready_consume", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("bp_d4_valid", rsp0_valid, 0);
        chk("bp_d4_q", rsp0_q, 0);
        tick();
        chk("stage_to_slot_valid", rsp0_valid, 1);
        chk("stage_to_slot_q", rsp0_q, 2'b10);
        tick();
        chk("stage_to_slot_consumed", rsp0_valid, 0);

        // Counter wrap: one accept per cycle for 257 cycles.
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        chk("wrap_255", op_count, 8'd255);
        tick();
        chk("wrap_0", op_count, 8'd0);
        tick();
        chk("wrap_1", op_count, 8'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        tick();

        // Reset one cycle after an accept discards the in-flight op.
        do_reset();
        req0_valid = 1'b1;
        req0_a = 2'b01;
        req0_b = 2'b01;
        rsp0_ready = 1'b1;
        #1;
        chk("midrst_accept", req0_ready, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ready0", req0_ready, 0);
        chk("midrst_count", op_count, 0);
        chk("midrst_rsp0_valid", rsp0_valid, 0);
        tick();
        rst_n = 1'b1;
        req0_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk($sformatf("midrst_no_rsp_%0d", j), rsp0_valid, 0);
            tick();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("midrst_prio_ready0", req0_ready, 1);
        chk("midrst_prio_ready1", req1_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
